// File: rtl/ht_head_table_if.sv
// Bus interface for ht_head_table: upstream request, downstream response,
// head-pointer write-back and status. The optional statistics signals exist
// only when HT_HEAD_TABLE_STATS_EN is defined.
interface ht_head_table_if #(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 16,
    parameter int BUCKET_WIDTH   = 8,
    parameter int HEAD_PTR_WIDTH = 10
) ();
    logic                      init_done_o;
    // upstream request
    logic [1:0]                cmd_i;
    logic [KEY_WIDTH-1:0]      key_i;
    logic [VALUE_WIDTH-1:0]    value_i;
    logic [BUCKET_WIDTH-1:0]   bucket_i;
    logic                      valid_i;
    logic                      ready_o;
    // downstream response
    logic [1:0]                cmd_o;
    logic [KEY_WIDTH-1:0]      key_o;
    logic [VALUE_WIDTH-1:0]    value_o;
    logic [BUCKET_WIDTH-1:0]   bucket_o;
    logic [HEAD_PTR_WIDTH-1:0] head_ptr_o;
    logic                      head_ptr_val_o;
    logic                      valid_o;
    logic                      ready_i;
    // head write-back from the data-table stage
    logic                      head_wr_en_i;
    logic [BUCKET_WIDTH-1:0]   head_wr_bucket_i;
    logic [HEAD_PTR_WIDTH-1:0] head_wr_ptr_i;
    logic                      head_wr_ptr_val_i;
`ifdef HT_HEAD_TABLE_STATS_EN
    logic [31:0]               lookup_cnt_o;
    logic [31:0]               empty_head_cnt_o;
`endif

    // Environment side: drives requests, downstream ready and write-backs.
    modport master (
`ifdef HT_HEAD_TABLE_STATS_EN
        input  lookup_cnt_o, empty_head_cnt_o,
`endif
        input  init_done_o, ready_o, cmd_o, key_o, value_o, bucket_o,
               head_ptr_o, head_ptr_val_o, valid_o,
        output cmd_i, key_i, value_i, bucket_i, valid_i, ready_i,
               head_wr_en_i, head_wr_bucket_i, head_wr_ptr_i, head_wr_ptr_val_i
    );

    // Head-table side.
    modport slave (
`ifdef HT_HEAD_TABLE_STATS_EN
        output lookup_cnt_o, empty_head_cnt_o,
`endif
        output init_done_o, ready_o, cmd_o, key_o, value_o, bucket_o,
               head_ptr_o, head_ptr_val_o, valid_o,
        input  cmd_i, key_i, value_i, bucket_i, valid_i, ready_i,
               head_wr_en_i, head_wr_bucket_i, head_wr_ptr_i, head_wr_ptr_val_i
    );
endinterface

// File: rtl/ht_head_table.sv
// Head-pointer lookup stage of the hash table pipeline. Sweeps the head RAM to
// empty after reset, then reads the head pointer of each accepted bucket and
// forwards it with the command one cycle later. Head writes from the data-table
// stage are forwarded into the output so it always matches RAM content.
// Optional lookup statistics: define HT_HEAD_TABLE_STATS_EN.
module ht_head_table #(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 16,
    parameter int BUCKET_WIDTH   = 8,
    parameter int HEAD_PTR_WIDTH = 10
) (
    input logic          clk_i,
    input logic          rst_i,
    ht_head_table_if.slave bus
);
    localparam int DEPTH    = 1 << BUCKET_WIDTH;
    localparam int HEAD_W   = HEAD_PTR_WIDTH + 1;   // {ptr_val, ptr}
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]              state;
    logic [BUCKET_WIDTH-1:0] init_addr;
    logic                    init_done;
    logic                    run;
    logic                    ready;
    logic                    xfer;

    logic [HEAD_W-1:0]       mem [DEPTH];
    logic                    ram_we;
    logic [BUCKET_WIDTH-1:0] ram_waddr;
    logic [HEAD_W-1:0]       ram_wdata;
    logic [HEAD_W-1:0]       ram_rdata;

    logic                    byp_sel;
    logic [HEAD_W-1:0]       byp_data;
    logic [HEAD_W-1:0]       wr_entry;
    logic                    wr_hit_in;
    logic                    wr_hit_out;

    logic [1:0]              cmd_q;
    logic [KEY_WIDTH-1:0]    key_q;
    logic [VALUE_WIDTH-1:0]  value_q;
    logic [BUCKET_WIDTH-1:0] bucket_q;
    logic                    valid_q;
    logic [HEAD_W-1:0]       head;

    assign run        = (state == ST_RUN);
    assign ready      = run && (!valid_q || bus.ready_i);
    assign xfer       = bus.valid_i && ready;
    assign wr_entry   = {bus.head_wr_ptr_val_i, bus.head_wr_ptr_i};
    assign wr_hit_in  = run && bus.head_wr_en_i && (bus.head_wr_bucket_i == bus.bucket_i);
    assign wr_hit_out = run && bus.head_wr_en_i && (bus.head_wr_bucket_i == bucket_q);

    // Init sweep counter and INIT -> RUN transition (RUN is terminal).
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_INIT;
            init_addr <= '0;
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            init_addr <= init_addr + 1'b1;
            if (&init_addr) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
        end
    end

    // RAM write port: clearing sweep in INIT, data-table write-back in RUN.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = bus.head_wr_bucket_i;
        ram_wdata = wr_entry;
        if (!run) begin
            ram_we    = 1'b1;
            ram_waddr = init_addr;
            ram_wdata = '0;
        end else if (bus.head_wr_en_i) begin
            ram_we    = 1'b1;
        end
    end

    // Head RAM: one write port, one registered read port enabled on transfer.
    // NOTE: the array is deliberately not reset; the INIT sweep clears it so it maps to block RAM.
    always_ff @(posedge clk_i) begin
        if (ram_we)
            mem[ram_waddr] <= ram_wdata;
        if (xfer)
            ram_rdata <= mem[bus.bucket_i];
    end

    // Forwarding register: overrides stale RAM read data when a write hits the
    // bucket being accepted or the bucket currently presented downstream.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byp_sel  <= 1'b1;
            byp_data <= '0;
        end else if (xfer) begin
            byp_sel  <= wr_hit_in;
            byp_data <= wr_entry;
        end else if (wr_hit_out) begin
            byp_sel  <= 1'b1;
            byp_data <= wr_entry;
        end
    end

    // Downstream output register with hold-on-stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_q    <= '0;
            key_q    <= '0;
            value_q  <= '0;
            bucket_q <= '0;
            valid_q  <= 1'b0;
        end else if (xfer) begin
            cmd_q    <= bus.cmd_i;
            key_q    <= bus.key_i;
            value_q  <= bus.value_i;
            bucket_q <= bus.bucket_i;
            valid_q  <= 1'b1;
        end else if (bus.ready_i) begin
            valid_q  <= 1'b0;
        end
    end

    assign head               = byp_sel ? byp_data : ram_rdata;
    assign bus.init_done_o    = init_done;
    assign bus.ready_o        = ready;
    assign bus.cmd_o          = cmd_q;
    assign bus.key_o          = key_q;
    assign bus.value_o        = value_q;
    assign bus.bucket_o       = bucket_q;
    assign bus.head_ptr_o     = head[HEAD_PTR_WIDTH-1:0];
    assign bus.head_ptr_val_o = head[HEAD_PTR_WIDTH];
    assign bus.valid_o        = valid_q;

`ifdef HT_HEAD_TABLE_STATS_EN
    logic [31:0] lookup_cnt;
    logic [31:0] empty_cnt;

    // Saturating counters of downstream transfers and of those with an empty head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lookup_cnt <= '0;
            empty_cnt  <= '0;
        end else if (valid_q && bus.ready_i) begin
            if (lookup_cnt != 32'hFFFF_FFFF)
                lookup_cnt <= lookup_cnt + 1'b1;
            if (!head[HEAD_PTR_WIDTH] && empty_cnt != 32'hFFFF_FFFF)
                empty_cnt <= empty_cnt + 1'b1;
        end
    end

    assign bus.lookup_cnt_o     = lookup_cnt;
    assign bus.empty_head_cnt_o = empty_cnt;
`endif
endmodule
